// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-through, no-write-allocate cache.
//
// Sits between a core memory port and the shared memory bus. Read hits are
// served with zero wait states; read misses refill a whole line one word at
// a time; every write goes to memory and also updates the cached word when
// it hits.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   s_valid/s_wr/s_addr/s_dataM2S   core request (held until s_ready)
//   s_ready            request accepted this cycle
//   s_dataS2M          registered read data, valid the cycle after acceptance
//   inv                one-cycle pulse that invalidates every line
//   m_valid/m_wr/m_addr/m_dataM2S   single-word memory request
//   m_ready/m_dataS2M  memory accept; read data valid in the accept cycle
//
// Optional build macro DM_CACHE_STATS_EN adds saturating hit_cnt/miss_cnt
// outputs (accepted read hits / refills started).
//
// States:
//   ST_IDLE   | serve hits, launch refill or memory write
//   ST_REFILL | read WORDS_PER_LINE words of the missed line from memory
//   ST_WRITE  | wait for memory to accept a write-through word

module dm_cache #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_dataM2S,
    output logic              s_ready,
    output logic [DATA_W-1:0] s_dataS2M,
    input  logic              inv,
    output logic              m_valid,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dataM2S,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_dataS2M
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int LSB_IDX = 2 + OFF_W;
    localparam int LSB_TAG = 2 + OFF_W + IDX_W;
    localparam int TAG_W   = ADDR_W - LSB_TAG;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_WRITE
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES*WORDS_PER_LINE];
    logic [OFF_W-1:0]  cnt_q;
    logic              inv_seen_q;

    logic [IDX_W-1:0]       s_idx, m_idx;
    logic [TAG_W-1:0]       s_tag, m_tag;
    logic [IDX_W+OFF_W-1:0] s_word, m_word;
    logic                   s_hit, m_hit, last_beat;
    logic                   refill_done, start_refill, start_write;
    logic [1:0]             unused_low;

    assign s_idx  = s_addr[LSB_TAG-1:LSB_IDX];
    assign s_tag  = s_addr[ADDR_W-1:LSB_TAG];
    assign s_word = s_addr[LSB_TAG-1:2];
    assign m_idx  = m_addr[LSB_TAG-1:LSB_IDX];
    assign m_tag  = m_addr[ADDR_W-1:LSB_TAG];
    assign m_word = m_addr[LSB_TAG-1:2];
    assign unused_low = s_addr[1:0] ^ m_addr[1:0];

    assign s_hit     = valid_q[s_idx] && (tag_arr[s_idx] == s_tag);
    assign m_hit     = valid_q[m_idx] && (tag_arr[m_idx] == m_tag);
    assign last_beat = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));

    assign refill_done  = (state_q == ST_REFILL) && m_ready && last_beat;
    assign start_refill = (state_q == ST_IDLE) && s_valid && !s_wr && !s_hit;
    assign start_write  = (state_q == ST_IDLE) && s_valid && s_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    if (s_wr)       state_d = ST_WRITE;
                    else if (s_hit) s_ready = 1'b1;
                    else            state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (m_ready && last_beat) state_d = ST_IDLE;
            end
            ST_WRITE: begin
                // An abandoned write still finishes on the bus, silently.
                if (m_ready) begin
                    s_ready = s_valid;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side request registers and refill bookkeeping. During a refill
    // m_addr walks the line and doubles as the refill target address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid    <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_dataM2S  <= '0;
            cnt_q      <= '0;
            inv_seen_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_write) begin
                        m_valid   <= 1'b1;
                        m_wr      <= 1'b1;
                        m_addr    <= {s_addr[ADDR_W-1:2], 2'b00};
                        m_dataM2S <= s_dataM2S;
                    end else if (start_refill) begin
                        m_valid    <= 1'b1;
                        m_wr       <= 1'b0;
                        m_addr     <= {s_addr[ADDR_W-1:LSB_IDX], {LSB_IDX{1'b0}}};
                        cnt_q      <= '0;
                        inv_seen_q <= 1'b0;
                    end
                end
                ST_REFILL: begin
                    if (inv) inv_seen_q <= 1'b1;
                    if (m_ready) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) m_valid <= 1'b0;
                        else           m_addr  <= m_addr + ADDR_W'(4);
                    end
                end
                ST_WRITE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_wr    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid bits: inv wins over everything; the refilled line is dropped
    // at refill start so a partial fill can never look valid, and is only
    // re-validated if no inv arrived while the fill was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (inv) begin
            valid_q <= '0;
        end else if (start_refill) begin
            valid_q[s_idx] <= 1'b0;
        end else if (refill_done && !inv_seen_q) begin
            valid_q[m_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           s_dataS2M <= '0;
        else if (s_valid && s_ready && !s_wr) s_dataS2M <= data_arr[s_word];
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (state_q == ST_REFILL && m_ready) begin
            data_arr[m_word] <= m_dataS2M;
            if (last_beat) tag_arr[m_idx] <= m_tag;
        end
        if (state_q == ST_WRITE && m_ready && m_hit) begin
            data_arr[m_word] <= m_dataM2S;
        end
    end

`ifdef DM_CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (s_valid && s_ready && !s_wr && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (start_refill && miss_cnt != '1)               miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: randomized and directed checks of dm_cache against a
// line-level reference model (valid/tag per index, flat memory image).
module tb_dm_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0, s_wr = 1'b0, inv = 1'b0;
    logic [31:0] s_addr = '0, s_dataM2S = '0;
    logic        s_ready;
    logic [31:0] s_dataS2M;
    logic        m_valid, m_wr, m_ready = 1'b0;
    logic [31:0] m_addr, m_dataM2S, m_dataS2M = '0;
`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int total = 0;
    int bad = 0;

    dm_cache dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_wr(s_wr), .s_addr(s_addr), .s_dataM2S(s_dataM2S),
        .s_ready(s_ready), .s_dataS2M(s_dataS2M), .inv(inv),
        .m_valid(m_valid), .m_wr(m_wr), .m_addr(m_addr), .m_dataM2S(m_dataM2S),
        .m_ready(m_ready), .m_dataS2M(m_dataS2M)
`ifdef DM_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- memory model and bus monitor ----------------
    logic [31:0] mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    int stall = 0, wait_cnt = 0;
    int cyc = 0, beats = 0, mv_cycles = 0, last_beat_cyc = 0, last_acc_cyc = 0;
    int unstable = 0, sready_viol = 0;
    bit hs_since = 0, prev_v = 0;
    logic [64:0] prev_req = '0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    bit          log_wr[$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h1000 + a;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h1000 + a;
    endfunction

    always @(negedge clk) begin
        if (rst && m_valid) begin
            if (wait_cnt >= stall) begin
                m_ready   = 1'b1;
                m_dataS2M = mem_rd(m_addr);
            end else begin
                m_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            m_ready  = 1'b0;
            wait_cnt = 0;
        end
        if (m_valid && prev_v && !hs_since && ({m_addr, m_wr, m_dataM2S} != prev_req))
            unstable++;
        prev_v   = m_valid;
        prev_req = {m_addr, m_wr, m_dataM2S};
        hs_since = 0;
    end

    always @(posedge clk) begin
        if (m_valid && m_ready) begin
            beats++;
            last_beat_cyc = cyc;
            log_addr.push_back(m_addr);
            log_data.push_back(m_dataM2S);
            log_wr.push_back(m_wr);
            if (m_wr) mem[m_addr] = m_dataM2S;
            wait_cnt = 0;
            hs_since = 1;
        end
        if (s_valid && s_ready) last_acc_cyc = cyc;
        if (s_ready && !s_valid) sready_viol++;
        if (m_valid) mv_cycles++;
        cyc++;
    end

    // ---------------- reference cache model ----------------
    bit          ref_valid [16];
    int unsigned ref_tag   [16];
    int exp_hit = 0, exp_miss = 0;

    task automatic ref_read(input logic [31:0] a, output bit hit);
        int unsigned idx = (a / 16) % 16;
        int unsigned tg  = a / 256;
        hit = ref_valid[idx] && ref_tag[idx] == tg;
        if (hit) exp_hit++;
        else     exp_miss++;
        ref_valid[idx] = 1;
        ref_tag[idx]   = tg;
    endtask

    task automatic ref_inv();
        foreach (ref_valid[i]) ref_valid[i] = 0;
    endtask

    // ---------------- core-side drivers (called at negedge) ----------------
    task automatic do_read(input logic [31:0] a, input int inv_at,
                           output logic [31:0] d, output int nb, output int ncyc, output bit ok);
        int b0 = beats;
        bit acc = 0, inv_done = 0;
        ncyc = 0;
        s_valid = 1; s_wr = 0; s_addr = a;
        while (1) begin
            if (inv_at >= 0 && !inv_done && beats - b0 >= inv_at) begin
                inv = 1; inv_done = 1;
            end else inv = 0;
            #1 acc = s_ready;
            @(posedge clk); ncyc++;
            @(negedge clk);
            if (acc || ncyc > 200) break;
        end
        inv = 0; s_valid = 0;
        d = s_dataS2M; nb = beats - b0; ok = acc;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            output int nb, output int lag, output bit ok);
        int b0 = beats, n = 0;
        bit acc = 0;
        s_valid = 1; s_wr = 1; s_addr = a; s_dataM2S = d;
        while (1) begin
            #1 acc = s_ready;
            @(posedge clk); n++;
            @(negedge clk);
            if (acc || n > 200) break;
        end
        s_valid = 0; s_wr = 0;
        nb = beats - b0; lag = last_acc_cyc - last_beat_cyc; ok = acc;
        ref_mem[{a[31:2], 2'b00}] = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        total++; if (m_valid !== 1'b0)  begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        total++; if (m_wr !== 1'b0)     begin bad++; $display("FAIL reset_m_wr got=%b want=0", m_wr); end
        total++; if (m_addr !== 32'h0)  begin bad++; $display("FAIL reset_m_addr got=%h want=0", m_addr); end
        total++; if (s_dataS2M !== 32'h0) begin bad++; $display("FAIL reset_s_data got=%h want=0", s_dataS2M); end
        total++; if (s_ready !== 1'b0)  begin bad++; $display("FAIL reset_s_ready got=%b want=0", s_ready); end
        @(negedge clk); rst = 1;
        @(negedge clk);
    endtask

    task automatic test_cold_read();
        logic [31:0] d; int nb, nc, mv0; bit ok, h;
        stall = 0;
        log_addr.delete(); log_data.delete(); log_wr.delete();
        do_read(32'h40, -1, d, nb, nc, ok); ref_read(32'h40, h);
        total++; if (!ok || nb != 4) begin bad++; $display("FAIL cold_beats got=%0d ok=%0b want=4", nb, ok); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_addr.size() <= i || log_addr[i] !== 32'h40 + 4*i) begin
                bad++; $display("FAIL cold_addr%0d got=%h want=%h", i,
                                (log_addr.size() > i) ? log_addr[i] : 32'hx, 32'h40 + 4*i);
            end
        end
        total++; if (last_acc_cyc - last_beat_cyc != 1) begin bad++; $display("FAIL cold_lag got=%0d want=1", last_acc_cyc - last_beat_cyc); end
        total++; if (d !== 32'h1040) begin bad++; $display("FAIL cold_data got=%h want=00001040", d); end
        mv0 = mv_cycles;
        do_read(32'h48, -1, d, nb, nc, ok); ref_read(32'h48, h);
        total++; if (!ok || nc != 1 || nb != 0) begin bad++; $display("FAIL hit_latency cyc=%0d beats=%0d want 1/0", nc, nb); end
        total++; if (mv_cycles != mv0) begin bad++; $display("FAIL hit_no_mvalid got=%0d want=0", mv_cycles - mv0); end
        total++; if (d !== 32'h1048) begin bad++; $display("FAIL hit_data got=%h want=00001048", d); end
    endtask

    task automatic test_write_hit();
        logic [31:0] d; int nb, nc, lag; bit ok, h;
        log_addr.delete(); log_data.delete(); log_wr.delete();
        do_write(32'h44, 32'hDEADBEEF, nb, lag, ok);
        total++; if (!ok || nb != 1 || lag != 0) begin bad++; $display("FAIL wr_hs beats=%0d lag=%0d want 1/0", nb, lag); end
        total++;
        if (log_addr.size() != 1 || log_addr[0] !== 32'h44 || log_data[0] !== 32'hDEADBEEF || !log_wr[0]) begin
            bad++; $display("FAIL wr_bus n=%0d want one write 44/deadbeef", log_addr.size());
        end
        do_read(32'h44, -1, d, nb, nc, ok); ref_read(32'h44, h);
        total++; if (!ok || nb != 0 || d !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_hit_read got=%h beats=%0d want deadbeef/0", d, nb); end
    endtask

    task automatic test_write_miss();
        logic [31:0] d; int nb, nc, lag; bit ok, h;
        do_write(32'h2000, 32'h12345678, nb, lag, ok);
        total++; if (!ok || nb != 1) begin bad++; $display("FAIL wmiss_beats got=%0d want=1", nb); end
        do_read(32'h2000, -1, d, nb, nc, ok); ref_read(32'h2000, h);
        total++; if (!ok || nb != 4 || d !== 32'h12345678) begin bad++; $display("FAIL wmiss_noalloc beats=%0d data=%h want 4/12345678", nb, d); end
    endtask

    task automatic test_conflict();
        logic [31:0] d; int nb, nc; bit ok, h;
        logic [31:0] seq [3] = '{32'h40, 32'h440, 32'h40};
        for (int i = 0; i < 3; i++) begin
            do_read(seq[i], -1, d, nb, nc, ok); ref_read(seq[i], h);
            total++;
            if (!ok || nb != (h ? 0 : 4) || d !== ref_rd(seq[i])) begin
                bad++; $display("FAIL conflict%0d beats=%0d data=%h want %0d/%h", i, nb, d, h ? 0 : 4, ref_rd(seq[i]));
            end
        end
    endtask

    task automatic test_inv();
        logic [31:0] d; int nb, nc; bit ok, h;
        do_read(32'h80, 2, d, nb, nc, ok); ref_inv(); ref_read(32'h80, h); exp_miss++;
        total++; if (!ok || nb != 8 || d !== 32'h1080) begin bad++; $display("FAIL inv_refill beats=%0d data=%h want 8/00001080", nb, d); end
        do_read(32'h84, 0, d, nb, nc, ok); ref_read(32'h84, h); ref_inv();
        total++; if (!ok || nb != 0 || d !== 32'h1084) begin bad++; $display("FAIL inv_hit beats=%0d data=%h want 0/00001084", nb, d); end
        do_read(32'h84, -1, d, nb, nc, ok); ref_read(32'h84, h);
        total++; if (!ok || nb != 4) begin bad++; $display("FAIL inv_after beats=%0d want=4", nb); end
    endtask

    task automatic test_stall_reset();
        logic [31:0] d; int nb, nc, rdy = 0; bit ok, h;
        stall = 5; unstable = 0;
        do_read(32'h100, -1, d, nb, nc, ok); ref_read(32'h100, h);
        total++; if (!ok || nb != 4 || d !== ref_rd(32'h100)) begin bad++; $display("FAIL stall_read beats=%0d data=%h", nb, d); end
        total++; if (unstable != 0) begin bad++; $display("FAIL stall_stable got=%0d want=0", unstable); end
        s_valid = 1; s_wr = 0; s_addr = 32'h300;
        for (int i = 0; i < 10; i++) begin #1 if (s_ready) rdy++; @(negedge clk); end
        #2 rst = 0;
        #1;
        total++; if (m_valid !== 1'b0 || rdy != 0) begin bad++; $display("FAIL rst_midfill m_valid=%b rdy=%0d want 0/0", m_valid, rdy); end
        s_valid = 0;
        @(negedge clk); rst = 1; @(negedge clk);
        ref_inv(); exp_hit = 0; exp_miss = 0; stall = 0;
        do_read(32'h300, -1, d, nb, nc, ok); ref_read(32'h300, h);
        total++; if (!ok || nb != 4 || d !== ref_rd(32'h300)) begin bad++; $display("FAIL rst_refill beats=%0d data=%h want 4", nb, d); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, wd; int nb, nc, lag; bit ok, h;
        for (int i = 0; i < 80; i++) begin
            stall = $urandom_range(0, 2);
            a = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 15) << 4) |
                ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) begin
                inv = 1; @(negedge clk); inv = 0; ref_inv();
            end
            if ($urandom_range(0, 3) == 0) begin
                wd = $urandom;
                log_addr.delete(); log_data.delete(); log_wr.delete();
                do_write(a, wd, nb, lag, ok);
                total++;
                if (!ok || nb != 1 || lag != 0 || log_addr.size() != 1 ||
                    log_addr[0] !== {a[31:2], 2'b00} || log_data[0] !== wd) begin
                    bad++; $display("FAIL rnd_wr%0d a=%h beats=%0d lag=%0d", i, a, nb, lag);
                end
            end else begin
                do_read(a, -1, d, nb, nc, ok); ref_read(a, h);
                total++;
                if (!ok || nb != (h ? 0 : 4) || d !== ref_rd({a[31:2], 2'b00})) begin
                    bad++; $display("FAIL rnd_rd%0d a=%h got=%h beats=%0d want=%h/%0d",
                                    i, a, d, nb, ref_rd({a[31:2], 2'b00}), h ? 0 : 4);
                end
            end
        end
        total++; if (sready_viol != 0) begin bad++; $display("FAIL sready_wo_svalid got=%0d want=0", sready_viol); end
    endtask

    task automatic test_stats();
`ifdef DM_CACHE_STATS_EN
        total++; if (hit_cnt !== 32'(exp_hit))   begin bad++; $display("FAIL hit_cnt got=%0d want=%0d", hit_cnt, exp_hit); end
        total++; if (miss_cnt !== 32'(exp_miss)) begin bad++; $display("FAIL miss_cnt got=%0d want=%0d", miss_cnt, exp_miss); end
`else
        $display("model hits=%0d misses=%0d", exp_hit, exp_miss);
`endif
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_inv();
        test_stall_reset();
        test_random();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
